// File: rtl/piso_frame_tx.sv
// -----------------------------------------------------------------------------
// piso_frame_tx
//
// Parallel-in/serial-out framed transmitter. A WIDTH-bit word is taken in
// over a valid/ready handshake. It is then driven onto a single serial line as:
//   - one start bit (0),
//   - WIDTH data bits,
//   - one stop bit (1).
// Each bit is held for BAUD_DIV clocks. The line idles high. This block is the
// sending end of the link that feeds the flip-flop-based SIPO receiver.
//
// Handshake (valid/ready):
//   A word transfers on the rising clk edge where in_valid && in_ready are both
//   high. in_data is copied into the shift register on that edge; any later
//   change to in_data is ignored. in_ready is high only in IDLE, so in_valid
//   has no effect while a frame is in flight. in_valid may be held high
//   continuously: the next word is then accepted in the done cycle and its
//   start bit follows on the next cycle.
//
// Parameters:
//   WIDTH      data bits per frame (>= 1)
//   BAUD_DIV   clocks per serial bit (>= 1)
//   LSB_FIRST  1: bit 0 goes out first (shift right)
//              0: bit WIDTH-1 goes out first (shift left)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   in_valid   in_data holds a word to send
//   in_ready   block can accept a word (high only in IDLE)
//   in_data    word to transmit; sampled only at the handshake
//   ser_out    serial line; idles high
//   busy       frame in progress (START/DATA/STOP)
//   done       one-cycle pulse in the cycle after the stop bit completes
//   dbg_state  current FSM state (0 IDLE, 1 START, 2 DATA, 3 STOP)
//
// Every output is a register or is decoded from registers only. No input
// reaches an output through combinational logic.
// -----------------------------------------------------------------------------
module piso_frame_tx #(
  parameter int WIDTH     = 8,
  parameter int BAUD_DIV  = 1,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             ser_out,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  // Counter widths, with a minimum of one bit, so that WIDTH=1 and
  // BAUD_DIV=1 still give legal vectors.
  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_next;
  logic [BW-1:0]    baud_q;
  logic [CW-1:0]    bit_q;
  logic             done_q;

  logic             accept;
  logic             baud_last;
  logic             bit_last;
  logic             tx_bit;

  // in_ready is decoded from the state register, so accept does not create
  // a combinational path from in_valid to any output.
  assign in_ready  = (state_q == S_IDLE);
  assign accept    = in_valid && in_ready;
  assign baud_last = (baud_q == BAUD_LAST);
  assign bit_last  = (bit_q == BIT_LAST);

  // The bit on the line is always at the output end of the shift register.
  // The register moves one place toward that end after each bit period.
  assign tx_bit     = LSB_FIRST ? shift_q[0] : shift_q[WIDTH-1];
  assign shift_next = LSB_FIRST ? (shift_q >> 1) : (shift_q << 1);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)                state_d = S_START;
      S_START: if (baud_last)             state_d = S_DATA;
      S_DATA:  if (baud_last && bit_last) state_d = S_STOP;
      S_STOP:  if (baud_last)             state_d = S_IDLE;
      default:                            state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    ser_out = 1'b1;
    case (state_q)
      S_START: ser_out = 1'b0;
      S_DATA:  ser_out = tx_bit;
      default: ser_out = 1'b1;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign dbg_state = state_q;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;

      // done is set by the final clock of the stop bit. It therefore shows up
      // in the first IDLE cycle, the same cycle in which in_ready returns.
      done_q <= (state_q == S_STOP) && baud_last;

      if (state_q == S_IDLE) begin
        // Counters are held at zero while idle. Every frame therefore starts
        // with a full-length start bit.
        baud_q <= '0;
        bit_q  <= '0;
        if (accept) begin
          shift_q <= in_data;
        end
      end else begin
        baud_q <= baud_last ? '0 : baud_q + 1'b1;
        if ((state_q == S_DATA) && baud_last) begin
          shift_q <= shift_next;
          bit_q   <= bit_last ? '0 : bit_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_piso_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_piso_frame_tx
//
// Bench for piso_frame_tx. It instantiates four configurations of the design:
//   u0  defaults (WIDTH 8, BAUD_DIV 1, LSB first)
//   u1  BAUD_DIV 4
//   u2  MSB first
//   u3  WIDTH 1
// All four share clk and rst.
//
// Outputs are sampled on the falling edge. Inputs are then driven on that same
// falling edge. Each word that is sent pushes its expected line pattern (one
// entry per clock) into exp_q. The queue is popped one entry per cycle as the
// DUT drives the line.
// -----------------------------------------------------------------------------
module tb_piso_frame_tx;

  localparam int W = 1;

  logic clk;
  logic rst;

  logic       v0, r0, s0, b0, dn0;
  logic [7:0] d0;
  logic [1:0] st0;

  logic       v1, r1, s1, b1, dn1;
  logic [7:0] d1;
  logic [1:0] st1;

  logic       v2, r2, s2, b2, dn2;
  logic [7:0] d2;
  logic [1:0] st2;

  logic       v3, r3, s3, b3, dn3;
  logic [0:0] d3;
  logic [1:0] st3;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp;

  int n_checks;
  int n_fail;

  // ---------------------------------------------------------------------------
  // DUTs
  // ---------------------------------------------------------------------------
  piso_frame_tx #(.WIDTH(8), .BAUD_DIV(1), .LSB_FIRST(1'b1)) u0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(r0), .in_data(d0),
    .ser_out(s0), .busy(b0), .done(dn0), .dbg_state(st0));

  piso_frame_tx #(.WIDTH(8), .BAUD_DIV(4), .LSB_FIRST(1'b1)) u1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_data(d1),
    .ser_out(s1), .busy(b1), .done(dn1), .dbg_state(st1));

  piso_frame_tx #(.WIDTH(8), .BAUD_DIV(1), .LSB_FIRST(1'b0)) u2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2), .in_data(d2),
    .ser_out(s2), .busy(b2), .done(dn2), .dbg_state(st2));

  piso_frame_tx #(.WIDTH(1), .BAUD_DIV(1), .LSB_FIRST(1'b1)) u3 (
    .clk(clk), .rst(rst), .in_valid(v3), .in_ready(r3), .in_data(d3),
    .ser_out(s3), .busy(b3), .done(dn3), .dbg_state(st3));

  // ---------------------------------------------------------------------------
  // Clock and watchdog
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Expected-line builder: one queue entry per clock of the frame.
  // ---------------------------------------------------------------------------
  task automatic push_frame(input logic [7:0] word, input int width,
                            input bit lsb, input int baud);
    logic [W-1:0] bv;
    for (int k = 0; k < baud; k++) exp_q.push_back(1'b0);
    for (int i = 0; i < width; i++) begin
      bv = lsb ? word[i] : word[width-1-i];
      for (int k = 0; k < baud; k++) exp_q.push_back(bv);
    end
    for (int k = 0; k < baud; k++) exp_q.push_back(1'b1);
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset;
    // Assert reset between clock edges; the outputs must change with no edge.
    #1 rst = 1'b0;
    #1;
    n_checks++; if (s0 !== 1'b1)   begin n_fail++; $display("FAIL reset_ser_out: got %b want 1", s0); end
    n_checks++; if (b0 !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b want 0", b0); end
    n_checks++; if (dn0 !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %b want 0", dn0); end
    n_checks++; if (r0 !== 1'b1)   begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", r0); end
    n_checks++; if (st0 !== 2'd0)  begin n_fail++; $display("FAIL reset_state: got %0d want 0", st0); end
    n_checks++; if ({s1, s2, s3} !== 3'b111) begin n_fail++; $display("FAIL reset_ser_out_others: got %b want 111", {s1, s2, s3}); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_frame;
    push_frame(8'hA5, 8, 1'b1, 1);
    @(negedge clk);
    n_checks++; if (r0 !== 1'b1) begin n_fail++; $display("FAIL basic_ready_before: got %b want 1", r0); end
    v0 = 1'b1; d0 = 8'hA5;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      n_checks++; if (s0 !== exp[0]) begin n_fail++; $display("FAIL basic_bit%0d: got %b want %b", c, s0, exp[0]); end
      n_checks++; if ({b0, dn0, r0} !== 3'b100) begin n_fail++; $display("FAIL basic_flags%0d: busy/done/ready got %b want 100", c, {b0, dn0, r0}); end
      v0 = 1'b0;
      d0 = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    n_checks++; if ({s0, b0, dn0, r0} !== 4'b1011) begin n_fail++; $display("FAIL basic_done_cycle: ser/busy/done/ready got %b want 1011", {s0, b0, dn0, r0}); end
    @(negedge clk);
    n_checks++; if (dn0 !== 1'b0) begin n_fail++; $display("FAIL basic_done_width: got %b want 0", dn0); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL basic_queue: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back;
    push_frame(8'h00, 8, 1'b1, 1);
    exp_q.push_back(1'b1);
    push_frame(8'hFF, 8, 1'b1, 1);
    @(negedge clk);
    v0 = 1'b1; d0 = 8'h00;
    for (int c = 0; c < 21; c++) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      n_checks++; if (s0 !== exp[0]) begin n_fail++; $display("FAIL b2b_line%0d: got %b want %b", c, s0, exp[0]); end
      if (c == 5) begin
        n_checks++; if (r0 !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_busy: got %b want 0", r0); end
      end
      if (c == 10) begin
        n_checks++; if ({dn0, r0, b0} !== 3'b110) begin n_fail++; $display("FAIL b2b_done_cycle: done/ready/busy got %b want 110", {dn0, r0, b0}); end
      end
      if (c == 0) d0 = 8'hFF;
      if (c == 11) v0 = 1'b0;
    end
    @(negedge clk);
    n_checks++; if ({dn0, b0} !== 2'b10) begin n_fail++; $display("FAIL b2b_final_done: done/busy got %b want 10", {dn0, b0}); end
    @(negedge clk);
  endtask

  task automatic test_baud_div;
    push_frame(8'h3C, 8, 1'b1, 4);
    @(negedge clk);
    v1 = 1'b1; d1 = 8'h3C;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      v1 = 1'b0;
      exp = exp_q.pop_front();
      n_checks++; if (s1 !== exp[0]) begin n_fail++; $display("FAIL baud_line%0d: got %b want %b", c, s1, exp[0]); end
      n_checks++; if (b1 !== 1'b1) begin n_fail++; $display("FAIL baud_busy%0d: got %b want 1", c, b1); end
    end
    @(negedge clk);
    n_checks++; if ({s1, b1, dn1, r1} !== 4'b1011) begin n_fail++; $display("FAIL baud_done_cycle: ser/busy/done/ready got %b want 1011", {s1, b1, dn1, r1}); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame;
    push_frame(8'h00, 8, 1'b1, 1);
    @(negedge clk);
    v0 = 1'b1; d0 = 8'h00;
    // Sample 0 is the start bit, so sample 4 is data bit 3.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      v0 = 1'b0;
      exp = exp_q.pop_front();
      n_checks++; if (s0 !== exp[0]) begin n_fail++; $display("FAIL abort_pre%0d: got %b want %b", c, s0, exp[0]); end
    end
    exp_q.delete();
    #1 rst = 1'b0;
    #1;
    n_checks++; if ({s0, b0, dn0, r0} !== 4'b1001) begin n_fail++; $display("FAIL abort_immediate: ser/busy/done/ready got %b want 1001", {s0, b0, dn0, r0}); end
    repeat (2) begin
      @(negedge clk);
      n_checks++; if (dn0 !== 1'b0) begin n_fail++; $display("FAIL abort_done_in_reset: got %b want 0", dn0); end
    end
    rst = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      n_checks++; if ({s0, dn0, r0} !== 3'b101) begin n_fail++; $display("FAIL abort_idle%0d: ser/done/ready got %b want 101", c, {s0, dn0, r0}); end
    end
    push_frame(8'h81, 8, 1'b1, 1);
    v0 = 1'b1; d0 = 8'h81;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      v0 = 1'b0;
      exp = exp_q.pop_front();
      n_checks++; if (s0 !== exp[0]) begin n_fail++; $display("FAIL abort_next%0d: got %b want %b", c, s0, exp[0]); end
    end
    @(negedge clk);
    n_checks++; if (dn0 !== 1'b1) begin n_fail++; $display("FAIL abort_next_done: got %b want 1", dn0); end
    @(negedge clk);
  endtask

  task automatic test_msb_first;
    push_frame(8'hA5, 8, 1'b0, 1);
    @(negedge clk);
    v2 = 1'b1; d2 = 8'hA5;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      v2 = 1'b0;
      exp = exp_q.pop_front();
      n_checks++; if (s2 !== exp[0]) begin n_fail++; $display("FAIL msb_line%0d: got %b want %b", c, s2, exp[0]); end
      if (c == 3) d2 = 8'h00;
    end
    @(negedge clk);
    n_checks++; if ({dn2, r2} !== 2'b11) begin n_fail++; $display("FAIL msb_done_cycle: done/ready got %b want 11", {dn2, r2}); end
    @(negedge clk);
  endtask

  task automatic test_width_one;
    push_frame(8'h01, 1, 1'b1, 1);
    exp_q.push_back(1'b1);
    push_frame(8'h00, 1, 1'b1, 1);
    @(negedge clk);
    v3 = 1'b1; d3 = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      n_checks++; if (s3 !== exp[0]) begin n_fail++; $display("FAIL w1_line%0d: got %b want %b", c, s3, exp[0]); end
      if (c == 3) begin
        n_checks++; if ({dn3, r3} !== 2'b11) begin n_fail++; $display("FAIL w1_done_cycle: done/ready got %b want 11", {dn3, r3}); end
      end
      if (c == 0) d3 = 1'b0;
      if (c == 4) v3 = 1'b0;
    end
    @(negedge clk);
    n_checks++; if ({dn3, b3} !== 2'b10) begin n_fail++; $display("FAIL w1_final_done: done/busy got %b want 10", {dn3, b3}); end
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    v0 = 1'b0; d0 = '0;
    v1 = 1'b0; d1 = '0;
    v2 = 1'b0; d2 = '0;
    v3 = 1'b0; d3 = '0;

    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_baud_div();
    test_reset_mid_frame();
    test_msb_first();
    test_width_one();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
